stream_demux_1_to_4: RTL
========================

// Module: stream_demux_1_to_4
// PURPOSE
//  Registered 1-to-4 stream demultiplexer with valid/ready handshake; inverse of the 4-to-1 read-data mux.
//  Steers one upstream request stream (e.g. SRAM command/data words) to one of four downstream ports by select.
//  Each output port has a one-entry register slice, so one port's back-pressure stalls only
//  the words addressed to that port.
// PARAMETERS
//  data_width   8   width of the data path, in bits
// PORTS
//  clk          in   1              single clock; all state changes on its rising edge
//  rst_n        in   1              asynchronous, active-low reset
//  select       in   2              destination port for the current input word (0..3)
//  in_valid     in   1              upstream word valid
//  in_ready     out  1              block accepts the word this cycle
//  data_i       in   data_width     upstream word
//  out_valid    out  4              bit k: port k holds a valid word
//  out_ready    in   4              bit k: downstream k takes the word this cycle
//  data_o_0     out  data_width     port 0 word; port 1 on data_o_1, port 2 on data_o_2, port 3 on data_o_3
//  stat_count   out  32             (DEMUX_STATS_EN only) per-port transfer counts, port k in [8k+7:8k]
// BEHAVIOUR
//  Reset (rst_n low, asynchronous):
//   - out_valid=0; data_o_0..3 = 0; stat_count = 0.
//   - Words held in the slices are discarded.
//   - in_ready evaluates to 1 while the slices are empty.
//  Per-port slice k has two states: EMPTY (out_valid[k]=0) and FULL (out_valid[k]=1).
//  Handshakes:
//   - Accept: acc = in_valid & in_ready.
//   - in_ready = ~out_valid[select] | out_ready[select]. This is combinational from select, out_ready and state.
//   - Drain k: out_valid[k] & out_ready[k].
//   - Load k: acc & (select==k); data_i is captured into data_o_k.
//  Slice transitions:
//   - EMPTY -load-> FULL.
//   - FULL -drain, no load-> EMPTY.
//   - FULL -drain and load (same cycle)-> FULL with new data: back-to-back, no bubble.
//   - FULL, no drain: data_o_k and out_valid[k] hold stable. No overwrite; in_ready=0 when select==k.
//  Latency and throughput:
//   - Latency is 1 cycle: a word accepted at edge N appears with out_valid high after edge N.
//   - Throughput is 1 word/cycle when the addressed port drains continuously.
//  Ordering and stalls:
//   - Words to the same port leave in arrival order.
//   - No reordering across ports at the input: a stall on the addressed port blocks the stream (head-of-line).
//   - Ports not addressed keep draining independently while the input is stalled.
//  Protocol rules:
//   - in_valid low: select and data_i are don't-care; no state change except drains.
//   - Upstream must hold data_i and select stable while in_valid & ~in_ready.
//  Reset mid-operation: all slices return to EMPTY immediately; words not yet drained are lost.
//  No X may propagate: out_valid is never X after reset, even if select is X while in_valid=0.
// CONFIGURATION
//  DEMUX_STATS_EN defined:
//   - Adds four 8-bit counters on the stat_count port.
//   - Counter k increments on each drain of port k.
//   - Counters saturate at 8'hFF; they clear only on reset.
//  DEMUX_STATS_EN undefined: no stat_count port and no counters; all other behaviour is identical.
// TESTING
//  1. Reset, then idle.
//     -> out_valid=4'b0000, data_o_* = 0, in_ready=1.
//  2. Word 8'hA5 to select=2, out_ready=4'b1111.
//     -> next cycle out_valid=4'b0100, data_o_2=8'hA5; no other port asserts.
//  3. Stream 8'h01..8'h08 to port 1, one word per cycle, out_ready[1]=1.
//     -> in_ready held at 1; port 1 emits 01..08 on consecutive cycles.
//  4. out_ready[3]=0; send 8'h11 to port 3, then 8'h22 to port 3.
//     -> second word stalls (in_ready=0) and data_o_3 holds 8'h11.
//     -> Raise out_ready[3]: 8'h22 loads in the same cycle 8'h11 drains.
//  5. Port 0 full and stalled while a word for port 0 waits on the input; port 2 holds 8'h33 with out_ready[2]=1.
//     -> port 2 drains 8'h33; the input stays blocked.
//  6. Pulse rst_n low mid-stream with ports 0 and 3 full.
//     -> out_valid drops to 0 asynchronously, before the next edge.
//     With DEMUX_STATS_EN: 300 drains on port 1 -> stat_count[15:8]=8'hFF.

Source files
------------

// File: rtl/stream_demux_1_to_4_if.sv
// Stream bundle for the 1-to-4 demux: one upstream channel, four registered ports.
// master drives the upstream word and downstream readies; slave is the demux.
interface stream_demux_1_to_4_if #(
    parameter int data_width = 8
);
    logic [1:0]            select;
    logic                  in_valid;
    logic                  in_ready;
    logic [data_width-1:0] data_i;
    logic [3:0]            out_valid;
    logic [3:0]            out_ready;
    logic [data_width-1:0] data_o_0;
    logic [data_width-1:0] data_o_1;
    logic [data_width-1:0] data_o_2;
    logic [data_width-1:0] data_o_3;

    modport master (
        output select, in_valid, data_i, out_ready,
        input  in_ready, out_valid,
        input  data_o_0, data_o_1, data_o_2, data_o_3
    );

    modport slave (
        input  select, in_valid, data_i, out_ready,
        output in_ready, out_valid,
        output data_o_0, data_o_1, data_o_2, data_o_3
    );
endinterface

// File: rtl/stream_demux_1_to_4.sv
// Registered 1-to-4 stream demux, one-entry slice per port.
// Define DEMUX_STATS_EN for saturating 8-bit per-port drain counters.
module stream_demux_1_to_4 #(
    parameter int data_width = 8
) (
    input  logic clk,
    input  logic rst_n,
`ifdef DEMUX_STATS_EN
    output logic [31:0] stat_count,
`endif
    stream_demux_1_to_4_if.slave bus
);
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_e;

    slot_e                 state_q [4];
    slot_e                 state_d [4];
    logic [data_width-1:0] data_q  [4];
    logic [data_width-1:0] data_d  [4];
    logic [3:0]            valid;
    logic [3:0]            drain;
    logic [3:0]            load;
    logic                  acc;

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            valid[k] = (state_q[k] == FULL);
        end
    end

    assign drain        = valid & bus.out_ready;
    assign bus.in_ready = ~valid[bus.select] | bus.out_ready[bus.select];
    assign acc          = bus.in_valid & bus.in_ready;

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            load[k] = acc & (bus.select == 2'(k));
        end
    end

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            state_d[k] = state_q[k];
            data_d[k]  = data_q[k];
            unique case (state_q[k])
                EMPTY: begin
                    if (load[k]) begin
                        state_d[k] = FULL;
                        data_d[k]  = bus.data_i;
                    end
                end
                FULL: begin
                    // a load here implies a same-cycle drain
                    if (load[k]) begin
                        data_d[k] = bus.data_i;
                    end else if (drain[k]) begin
                        state_d[k] = EMPTY;
                    end
                end
                default: state_d[k] = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                state_q[k] <= EMPTY;
                data_q[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                state_q[k] <= state_d[k];
                data_q[k]  <= data_d[k];
            end
        end
    end

    assign bus.out_valid = valid;
    assign bus.data_o_0  = data_q[0];
    assign bus.data_o_1  = data_q[1];
    assign bus.data_o_2  = data_q[2];
    assign bus.data_o_3  = data_q[3];

`ifdef DEMUX_STATS_EN
    logic [7:0] cnt_q [4];
    logic [7:0] cnt_d [4];

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            cnt_d[k] = cnt_q[k];
            if (drain[k] && cnt_q[k] != 8'hFF) begin
                cnt_d[k] = cnt_q[k] + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    assign stat_count = {cnt_q[3], cnt_q[2], cnt_q[1], cnt_q[0]};
`endif
endmodule
